// File: rtl/add_arb.sv
`default_nettype none
// ============================================================================
//  Module   : add_arb
//  Purpose  : Two-port round-robin arbiter in front of a shared 16-bit
//             carry-lookahead saturating adder. The result, flags and owner
//             ID are captured in a single-entry response register that
//             honours downstream backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module add_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req0_ci,
    input  logic        req1_ci,
    input  logic [1:0]  req0_mode,
    input  logic [1:0]  req1_mode,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_sum,
    output logic [2:0]  resp_flags,
    output logic        resp_err
);

    typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q;
    logic        prio_q;
    logic        id_q;
    logic [15:0] sum_q;
    logic [2:0]  flags_q;
    logic        err_q;

    logic        can_accept;
    logic [1:0]  gnt;
    logic [15:0] op_a, op_b;
    logic        op_ci;
    logic [1:0]  op_mode;
    logic        sat16, sat4;
    logic [15:0] raw;
    logic        ovf;
    logic [15:0] sum_d;
    logic [2:0]  flags_d;
    logic        err_d;

    // Four-bit lookahead slice: all internal carries from generate/propagate.
    function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                            input logic c0);
        logic [3:0] p, g, c;
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return p ^ c;
    endfunction

    assign can_accept = (state_q == EMPTY) | resp_ready;
    assign req_ready  = gnt;
    assign resp_valid = (state_q == FULL);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_flags = flags_q;
    assign resp_err   = err_q;

    // Round-robin grant: a lone requester wins, a tie goes to the prio port.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = can_accept & req_valid[0] & (~req_valid[1] | ~prio_q);
        gnt[1] = can_accept & req_valid[1] & (~req_valid[0] |  prio_q);
    end

    // Shared adder: operand mux, two-level lookahead, saturation and flags.
    always_comb begin
        logic [3:0] gg, gp;
        logic [3:0] cin;
        logic [15:0] p, g;
        op_a    = gnt[1] ? req1_a    : req0_a;
        op_b    = gnt[1] ? req1_b    : req0_b;
        op_ci   = gnt[1] ? req1_ci   : req0_ci;
        op_mode = gnt[1] ? req1_mode : req0_mode;
        sat16   = (op_mode == 2'b01);
        sat4    = (op_mode == 2'b10);

        p = op_a ^ op_b;
        g = op_a & op_b;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        // Nibble mode cuts the group carries so each lane adds independently.
        cin[0] = op_ci;
        cin[1] = ~sat4 & (gg[0] | (gp[0] & op_ci));
        cin[2] = ~sat4 & (gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & op_ci));
        cin[3] = ~sat4 & (gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                        | (gp[2] & gp[1] & gp[0] & op_ci));
        for (int k = 0; k < 4; k++) begin
            raw[4*k +: 4] = cla4_sum(op_a[4*k +: 4], op_b[4*k +: 4], cin[k]);
        end

        ovf   = (op_a[15] == op_b[15]) & (raw[15] != op_a[15]);
        sum_d = raw;
        if (sat16 && ovf) begin
            sum_d = op_a[15] ? 16'h8000 : 16'h7FFF;
        end
        if (sat4) begin
            for (int k = 0; k < 4; k++) begin
                if ((op_a[4*k+3] == op_b[4*k+3]) && (raw[4*k+3] != op_a[4*k+3])) begin
                    sum_d[4*k +: 4] = op_a[4*k+3] ? 4'h8 : 4'h7;
                end
            end
        end
        flags_d = {(sum_d == 16'h0000), ovf, sum_d[15]};
        err_d   = (op_mode == 2'b11);
    end

    // Response FSM, priority pointer and registered response contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= 16'h0000;
            flags_q <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            if (|gnt) begin
                prio_q  <= ~gnt[1];
                id_q    <= gnt[1];
                sum_q   <= sum_d;
                flags_q <= flags_d;
                err_q   <= err_d;
            end
            case (state_q)
                EMPTY:   if (|gnt) state_q <= FULL;
                FULL:    if (resp_ready && !(|gnt)) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_arb
//  Purpose  : Self-checking bench for add_arb with a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ci, req1_ci;
    logic [1:0]  req0_mode, req1_mode;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [15:0] resp_sum;
    logic [2:0]  resp_flags;
    logic        resp_err;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic [2:0]  flags;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    add_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ci    (req0_ci),
        .req1_ci    (req1_ci),
        .req0_mode  (req0_mode),
        .req1_mode  (req1_mode),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_flags (resp_flags),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on signed integers, independent of adder structure.
    function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic [1:0] mode);
        exp_t        e;
        logic [15:0] raw, s;
        logic signed [3:0] na, nb;
        int          sa, lane;
        raw = a + b + {15'd0, ci};
        if (mode == 2'b10) begin
            for (int k = 0; k < 4; k++) begin
                raw[4*k +: 4] = a[4*k +: 4] + b[4*k +: 4] + ((k == 0) ? {3'd0, ci} : 4'd0);
            end
        end
        s = raw;
        if (mode == 2'b01) begin
            sa = int'($signed(a)) + int'($signed(b)) + int'(ci);
            if (sa > 32767)       s = 16'h7FFF;
            else if (sa < -32768) s = 16'h8000;
            else                  s = sa[15:0];
        end else if (mode == 2'b10) begin
            for (int k = 0; k < 4; k++) begin
                na   = a[4*k +: 4];
                nb   = b[4*k +: 4];
                lane = int'(na) + int'(nb) + ((k == 0) ? int'(ci) : 0);
                if (lane > 7)       s[4*k +: 4] = 4'h7;
                else if (lane < -8) s[4*k +: 4] = 4'h8;
                else                s[4*k +: 4] = lane[3:0];
            end
        end
        e.id    = id;
        e.sum   = s;
        e.flags = {(s == 16'h0), (a[15] == b[15]) && (raw[15] != a[15]), s[15]};
        e.err   = (mode == 2'b11);
        return e;
    endfunction

    // Scoreboard: retire on response handshake, record on request acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("resp_id",    {31'd0, resp_id},    {31'd0, e.id});
                    check_val("resp_sum",   {16'd0, resp_sum},   {16'd0, e.sum});
                    check_val("resp_flags", {29'd0, resp_flags}, {29'd0, e.flags});
                    check_val("resp_err",   {31'd0, resp_err},   {31'd0, e.err});
                end
            end
            check_val("ready_onehot",  {31'd0, req_ready[0] & req_ready[1]}, 32'd0);
            check_val("ready_wo_valid", {30'd0, req_ready & ~req_valid}, 32'd0);
            if (req_valid[0] && req_ready[0]) sb.push_back(model(1'b0, req0_a, req0_b, req0_ci, req0_mode));
            if (req_valid[1] && req_ready[1]) sb.push_back(model(1'b1, req1_a, req1_b, req1_ci, req1_mode));
        end
    end

    task automatic set_port(input logic port, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic [1:0] mode);
        if (port) begin
            req1_a = a; req1_b = b; req1_ci = ci; req1_mode = mode;
        end else begin
            req0_a = a; req0_b = b; req0_ci = ci; req0_mode = mode;
        end
    endtask

    // Single request on one port with the consumer ready; expects acceptance.
    task automatic send(input logic port, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [1:0] mode);
        set_port(port, a, b, ci, mode);
        req_valid = port ? 2'b10 : 2'b01;
        @(negedge clk);
        check_val("ready_single", {30'd0, req_ready}, port ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check_val("resp_valid_lat", {31'd0, resp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
        set_port(1'b0, 16'h0, 16'h0, 1'b0, 2'b00);
        set_port(1'b1, 16'h0, 16'h0, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_resp_sum",   {16'd0, resp_sum},   32'd0);
        check_val("rst_req_ready",  {30'd0, req_ready},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(1'b0, 16'h1234, 16'h0001, 1'b0, 2'b00);
        send(1'b0, 16'h7000, 16'h7000, 1'b0, 2'b01);
        send(1'b0, 16'h9000, 16'h9000, 1'b0, 2'b01);
        send(1'b0, 16'h7777, 16'h1111, 1'b0, 2'b10);
        send(1'b0, 16'h8888, 16'h8888, 1'b0, 2'b10);
        for (int i = 0; i < 6; i++) begin
            send(i[0], 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
        end

        // Last single request went to port 1, so port 0 is favoured next.
        set_port(1'b0, 16'h0011, 16'h0022, 1'b0, 2'b00);
        set_port(1'b1, 16'h7FFF, 16'h0000, 1'b1, 2'b01);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rr_grant", {30'd0, req_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i > 0) check_val("rr_no_bubble", {31'd0, resp_valid}, 32'd1);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;

        // Backpressure: fill from port 0 (prio becomes 1), then stall.
        send(1'b0, 16'h0100, 16'h0200, 1'b0, 2'b00);
        resp_ready = 1'b0;
        set_port(1'b0, 16'h0005, 16'h0006, 1'b0, 2'b00);
        set_port(1'b1, 16'h8000, 16'hFFFF, 1'b0, 2'b01);
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_ready",  {30'd0, req_ready},  32'd0);
            check_val("bp_valid",  {31'd0, resp_valid}, 32'd1);
            check_val("bp_sum",    {16'd0, resp_sum},   32'h0300);
            check_val("bp_id",     {31'd0, resp_id},    32'd0);
            check_val("bp_flags",  {29'd0, resp_flags}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release_grant", {30'd0, req_ready}, 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;

        // Reserved mode, then reset while the response is held.
        send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 2'b11);
        resp_ready = 1'b0;
        @(negedge clk);
        check_val("rsv_valid", {31'd0, resp_valid}, 32'd1);
        check_val("rsv_sum",   {16'd0, resp_sum},   32'd0);
        check_val("rsv_flags", {29'd0, resp_flags}, 32'h4);
        check_val("rsv_err",   {31'd0, resp_err},   32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", {31'd0, resp_valid}, 32'd0);
        check_val("arst_id",    {31'd0, resp_id},    32'd0);
        check_val("arst_sum",   {16'd0, resp_sum},   32'd0);
        check_val("arst_flags", {29'd0, resp_flags}, 32'd0);
        check_val("arst_err",   {31'd0, resp_err},   32'd0);
        sb.delete();

        // Release between edges; prio is back to port 0.
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        set_port(1'b0, 16'h4000, 16'h4000, 1'b0, 2'b01);
        set_port(1'b1, 16'h0001, 16'h0001, 1'b0, 2'b00);
        req_valid = 2'b11;
        @(negedge clk);
        check_val("post_rst_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;
        check_val("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
